uctl_fifo_rd_ctrl: RTL and testbench
====================================

UCTL_FIFO_RD_CTRL -- requirements
Module: uctl_fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter FIFO_ADDRSIZE, default 2: RAM address width; depth 2^FIFO_ADDRSIZE.
REQ-002 SHALL have parameter FIFO_DATAW, default 32: data word width.
REQ-003 SHALL have port rclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rrst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rq2_wptr, input, FIFO_ADDRSIZE+1 bits: Gray write pointer, already synchronized into rclk.
REQ-006 SHALL have port rptr, output, FIFO_ADDRSIZE+1 bits: registered Gray read pointer, sent to the write domain.
REQ-007 SHALL have port raddr, output, FIFO_ADDRSIZE bits: binary RAM read address, equal to rbin[FIFO_ADDRSIZE-1:0].
REQ-008 SHALL have port rd_en, output, 1 bit: combinational RAM read strobe.
REQ-009 SHALL have port rdata_ram, input, FIFO_DATAW bits: RAM read data, valid in the cycle after rd_en.
REQ-010 SHALL have port m_data, output, FIFO_DATAW bits: registered output word.
REQ-011 SHALL have port m_valid, output, 1 bit: m_data holds a valid word.
REQ-012 SHALL have port m_ready, input, 1 bit: consumer accepts; pop = m_valid && m_ready.
REQ-013 SHALL have port rflush, input, 1 bit: discard all unread data.
REQ-014 SHALL have port rempty, output, 1 bit: registered flag, RAM-side FIFO empty.
REQ-015 SHALL have port rlevel, output, FIFO_ADDRSIZE+1 bits: registered count of RAM-side unread entries.

Function
REQ-016 SHALL keep binary read pointer rbin (FIFO_ADDRSIZE+1 bits); rbin_next = rbin + rd_en, wrapping modulo 2^(FIFO_ADDRSIZE+1).
REQ-017 SHALL register rptr <= bin2gray(rbin_next) and rempty <= (bin2gray(rbin_next) == rq2_wptr) every cycle.
REQ-018 SHALL implement output FSM states IDLE (no word held, no read pending), FETCH (read pending, m_valid=0) and HOLD (m_valid=1).
REQ-019 SHALL assert rd_en = !rempty && !rflush && (state==IDLE || (state==HOLD && m_ready)).
REQ-020 SHALL make FSM transitions: IDLE -rd_en-> FETCH; FETCH -> HOLD unconditionally, m_data <= rdata_ram; HOLD -pop&&rd_en-> FETCH; HOLD -pop&&!rd_en-> IDLE; otherwise stay.
REQ-021 SHALL hold m_data stable while m_valid && !m_ready, and issue no rd_en then.
REQ-022 SHALL give a sustained throughput of one word per 2 cycles; latency from rd_en to m_valid is 2 edges.
REQ-023 On rflush, SHALL at the next edge force: rbin <= gray2bin(rq2_wptr), rptr <= rq2_wptr, rempty <= 1, state <= IDLE, m_valid <= 0; a read pending in FETCH is discarded; rflush has priority over pop and rd_en.
REQ-024 SHALL never assert rd_en while rempty=1 (no underflow), including at pointer wrap.

Reset
REQ-025 While rrst is high at an edge, SHALL set rbin=0, rptr=0, rempty=1, state=IDLE, m_valid=0, m_data=0, rlevel=0, and force rd_en=0 combinationally.
REQ-026 SHALL give rrst priority over rflush; rrst asserted mid-FETCH discards the pending read.

Configuration
REQ-027 With macro UCTL_RD_LEVEL_EN defined, SHALL register rlevel <= gray2bin(rq2_wptr) - rbin_next (modulo 2^(FIFO_ADDRSIZE+1)), and 0 on flush.
REQ-028 Without UCTL_RD_LEVEL_EN, SHALL tie rlevel constant 0, add no level logic, and keep the port present.

Verification (FIFO_ADDRSIZE=2)
REQ-029 SHALL cover reset: rrst=1 for 2 cycles, rq2_wptr=000 -> rempty=1, rptr=000, m_valid=0, rd_en=0, rlevel=0.
REQ-030 SHALL cover single word: rq2_wptr 000->001 at edge E0, RAM[0]=0xA5A50001, m_ready=0 -> rempty=0 after E1; rd_en=1 with raddr=0 in the cycle after E1; rempty=1 after E2; m_valid=1 with m_data=0xA5A50001 after E3.
REQ-031 SHALL cover wrap: 9 words streamed with m_ready=1 -> rptr steps 000,001,011,010,110,111,101,100,000; no rd_en while rempty=1.
REQ-032 SHALL cover backpressure: rq2_wptr=110 (4 entries), m_ready=0 -> exactly one rd_en, m_data stable, rlevel=3 (macro on).
REQ-033 SHALL cover flush: m_valid=1, 3 entries, rflush pulse -> next cycle m_valid=0, rempty=1, rptr==rq2_wptr, rlevel=0, state=IDLE.
REQ-034 SHALL cover macro off: repeat REQ-032 -> rlevel=0 throughout.

Source files
------------

// File: rtl/uctl_fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: Gray pointer/empty tracking plus a one-word registered output stage.
// Optional macro UCTL_RD_LEVEL_EN enables the registered rlevel occupancy count (tied to 0 otherwise).
module uctl_fifo_rd_ctrl #(
    parameter int unsigned FIFO_ADDRSIZE = 2,
    parameter int unsigned FIFO_DATAW    = 32
) (
    input  logic                     rclk,
    input  logic                     rrst,
    input  logic [FIFO_ADDRSIZE:0]   rq2_wptr,
    output logic [FIFO_ADDRSIZE:0]   rptr,
    output logic [FIFO_ADDRSIZE-1:0] raddr,
    output logic                     rd_en,
    input  logic [FIFO_DATAW-1:0]    rdata_ram,
    output logic [FIFO_DATAW-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    input  logic                     rflush,
    output logic                     rempty,
    output logic [FIFO_ADDRSIZE:0]   rlevel
);

    localparam int unsigned PW = FIFO_ADDRSIZE + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic          pop;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int i = 1; i < int'(PW); i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // A new RAM read is issued only when the output register is free or being drained this cycle.
    assign pop       = m_valid && m_ready;
    assign rd_en     = !rrst && !rempty && !rflush &&
                       ((state == IDLE) || ((state == HOLD) && m_ready));
    assign rbin_next = rbin + PW'(rd_en);
    assign raddr     = rbin[FIFO_ADDRSIZE-1:0];

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            state   <= IDLE;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (rflush) begin
            // Jump to the writer's position; any read still in flight is dropped.
            rbin    <= gray2bin(rq2_wptr);
            rptr    <= rq2_wptr;
            rempty  <= 1'b1;
            state   <= IDLE;
            m_valid <= 1'b0;
        end else begin
            rbin   <= rbin_next;
            rptr   <= bin2gray(rbin_next);
            rempty <= (bin2gray(rbin_next) == rq2_wptr);
            case (state)
                IDLE: begin
                    if (rd_en) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    state   <= HOLD;
                    m_valid <= 1'b1;
                    m_data  <= rdata_ram;
                end
                HOLD: begin
                    if (pop) begin
                        m_valid <= 1'b0;
                        state   <= rd_en ? FETCH : IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef UCTL_RD_LEVEL_EN
    // Unread RAM entries as seen after this cycle's read.
    always_ff @(posedge rclk) begin
        if (rrst || rflush) begin
            rlevel <= '0;
        end else begin
            rlevel <= gray2bin(rq2_wptr) - rbin_next;
        end
    end
`else
    assign rlevel = '0;
`endif

endmodule

// File: tb/tb_uctl_fifo_rd_ctrl.sv
// Directed bench for uctl_fifo_rd_ctrl (FIFO_ADDRSIZE=2): vector table plus hand-written multi-cycle sequences.
module tb_uctl_fifo_rd_ctrl;

    localparam int unsigned AW = 2;
    localparam int unsigned PW = 3;
    localparam int unsigned DW = 32;
`ifdef UCTL_RD_LEVEL_EN
    localparam bit LVL_ON = 1'b1;
`else
    localparam bit LVL_ON = 1'b0;
`endif

    logic          rclk = 1'b0;
    logic          rrst;
    logic [PW-1:0] rq2_wptr;
    logic [PW-1:0] rptr;
    logic [AW-1:0] raddr;
    logic          rd_en;
    logic [DW-1:0] rdata_ram = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          rflush;
    logic          rempty;
    logic [PW-1:0] rlevel;

    logic [DW-1:0] mem [4];
    logic [PW-1:0] gtab [8];

    int errors = 0;
    int checks = 0;

    always #5 rclk = ~rclk;

    uctl_fifo_rd_ctrl #(.FIFO_ADDRSIZE(AW), .FIFO_DATAW(DW)) dut (
        .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .rptr(rptr), .raddr(raddr),
        .rd_en(rd_en), .rdata_ram(rdata_ram), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .rflush(rflush), .rempty(rempty), .rlevel(rlevel)
    );

    // RAM model: data appears the cycle after the read strobe.
    always @(posedge rclk) begin
        if (rd_en) rdata_ram <= mem[raddr];
    end

    typedef struct {
        logic          rst;
        logic          flush;
        logic          rdy;
        logic [PW-1:0] wptr;
        logic          e_rd_en;
        logic [AW-1:0] e_raddr;
        logic          e_rempty;
        logic [PW-1:0] e_rptr;
        logic          e_mvalid;
        logic [DW-1:0] e_mdata;
        logic [PW-1:0] e_lvl;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic rst, input logic flush, input logic rdy,
                                input logic [PW-1:0] wptr, input logic e_rd_en,
                                input logic [AW-1:0] e_raddr, input logic e_rempty,
                                input logic [PW-1:0] e_rptr, input logic e_mvalid,
                                input logic [DW-1:0] e_mdata, input logic [PW-1:0] e_lvl);
        vec_t v;
        v.rst = rst; v.flush = flush; v.rdy = rdy; v.wptr = wptr;
        v.e_rd_en = e_rd_en; v.e_raddr = e_raddr; v.e_rempty = e_rempty;
        v.e_rptr = e_rptr; v.e_mvalid = e_mvalid; v.e_mdata = e_mdata; v.e_lvl = e_lvl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Leaves the bench just after a falling edge with reset released.
    task automatic reset_dut(input logic [PW-1:0] w);
        rrst     = 1'b1;
        rflush   = 1'b0;
        m_ready  = 1'b0;
        rq2_wptr = w;
        repeat (2) @(negedge rclk);
        rrst = 1'b0;
    endtask

    initial begin
        int nrd;
        int npop;
        int w;
        int got;
        logic s_rd, s_emp, s_pop;
        logic [DW-1:0] s_data;

        for (int k = 0; k < 4; k++) mem[k] = 32'hA5A5_0001 + 32'(k);
        gtab[0] = 3'b000; gtab[1] = 3'b001; gtab[2] = 3'b011; gtab[3] = 3'b010;
        gtab[4] = 3'b110; gtab[5] = 3'b111; gtab[6] = 3'b101; gtab[7] = 3'b100;

        //             rst   flush rdy   wptr    rd_en raddr rempty rptr    mvalid mdata          lvl
        vecs[0] = mk(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 1'b1, 3'b000, 1'b0, 32'h0,         3'd0);
        vecs[1] = mk(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 1'b1, 3'b000, 1'b0, 32'h0,         3'd0);
        vecs[2] = mk(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 1'b1, 3'b000, 1'b0, 32'h0,         3'd0);
        vecs[3] = mk(1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0, 32'h0,         3'd1);
        vecs[4] = mk(1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 2'd0, 1'b1, 3'b001, 1'b0, 32'h0,         3'd0);
        vecs[5] = mk(1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 2'd0, 1'b1, 3'b001, 1'b1, 32'hA5A50001, 3'd0);
        vecs[6] = mk(1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 2'd0, 1'b1, 3'b001, 1'b0, 32'hA5A50001, 3'd0);
        vecs[7] = mk(1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 2'd0, 1'b0, 3'b001, 1'b0, 32'hA5A50001, 3'd1);
        vecs[8] = mk(1'b0, 1'b0, 1'b1, 3'b011, 1'b1, 2'd1, 1'b1, 3'b011, 1'b0, 32'hA5A50001, 3'd0);
        vecs[9] = mk(1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 2'd0, 1'b1, 3'b011, 1'b1, 32'hA5A50002, 3'd0);

        rrst = 1'b1; rflush = 1'b0; m_ready = 1'b0; rq2_wptr = '0;
        @(negedge rclk);

        // Reset and single-word / second-word walk, one vector per clock.
        for (int i = 0; i < 10; i++) begin
            rrst = vecs[i].rst; rflush = vecs[i].flush; m_ready = vecs[i].rdy; rq2_wptr = vecs[i].wptr;
            #1;
            check($sformatf("v%0d_rd_en", i), 32'(rd_en), 32'(vecs[i].e_rd_en));
            if (vecs[i].e_rd_en) check($sformatf("v%0d_raddr", i), 32'(raddr), 32'(vecs[i].e_raddr));
            @(posedge rclk); #1;
            check($sformatf("v%0d_rempty", i), 32'(rempty), 32'(vecs[i].e_rempty));
            check($sformatf("v%0d_rptr", i), 32'(rptr), 32'(vecs[i].e_rptr));
            check($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_mvalid));
            check($sformatf("v%0d_m_data", i), m_data, vecs[i].e_mdata);
            check($sformatf("v%0d_rlevel", i), 32'(rlevel), LVL_ON ? 32'(vecs[i].e_lvl) : 32'd0);
            @(negedge rclk);
        end

        // Wrap: stream 9 words, writer kept two entries ahead of the reader.
        reset_dut(3'b000);
        m_ready = 1'b1;
        nrd = 0; npop = 0;
        for (int c = 0; c < 200 && npop < 9; c++) begin
            w = (nrd + 2 > 9) ? 9 : nrd + 2;
            rq2_wptr = gtab[3'(w)];
            #1;
            s_rd = rd_en; s_emp = rempty; s_pop = m_valid && m_ready; s_data = m_data;
            check("wrap_no_underflow", 32'(s_rd && s_emp), 32'd0);
            @(posedge rclk); #1;
            if (s_rd) begin
                nrd++;
                check($sformatf("wrap_rptr_%0d", nrd), 32'(rptr), 32'(gtab[3'(nrd)]));
            end
            if (s_pop) begin
                check($sformatf("wrap_data_%0d", npop), s_data, mem[2'(npop)]);
                npop++;
            end
            @(negedge rclk);
        end
        check("wrap_words", 32'(npop), 32'd9);
        check("wrap_final_rptr", 32'(rptr), 32'(3'b001));

        // Backpressure: 4 entries, consumer stalled; exactly one read issued.
        reset_dut(3'b110);
        nrd = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (rd_en) nrd++;
            @(posedge rclk);
            @(negedge rclk);
        end
        check("bp_rd_count", 32'(nrd), 32'd1);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_no_rd_en", 32'(rd_en), 32'd0);
            @(posedge rclk); #1;
            check("bp_data_stable", m_data, mem[0]);
            @(negedge rclk);
        end
        check("bp_rlevel", 32'(rlevel), LVL_ON ? 32'd3 : 32'd0);

        // Flush while holding a word with 3 entries left; flush beats the pop.
        rflush = 1'b1; m_ready = 1'b1;
        #1;
        check("flush_rd_en_blocked", 32'(rd_en), 32'd0);
        @(posedge rclk); #1;
        check("flush_m_valid", 32'(m_valid), 32'd0);
        check("flush_rempty", 32'(rempty), 32'd1);
        check("flush_rptr", 32'(rptr), 32'(3'b110));
        check("flush_rlevel", 32'(rlevel), 32'd0);
        @(negedge rclk);
        rflush = 1'b0;
        #1;
        check("flush_after_rd_en", 32'(rd_en), 32'd0);
        @(posedge rclk); #1;
        check("flush_after_m_valid", 32'(m_valid), 32'd0);
        check("flush_after_rempty", 32'(rempty), 32'd1);
        check("flush_after_raddr", 32'(raddr), 32'd0);
        check("flush_after_rlevel", 32'(rlevel), 32'd0);
        @(negedge rclk);

        // Flush while a read is in flight: the fetched word is dropped.
        reset_dut(3'b000);
        rq2_wptr = 3'b001;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            #1;
            got = int'(rd_en);
            @(posedge rclk);
            @(negedge rclk);
        end
        check("fetch_rd_seen", 32'(got), 32'd1);
        rflush = 1'b1;
        @(posedge rclk); #1;
        check("fetch_flush_m_valid", 32'(m_valid), 32'd0);
        @(negedge rclk);
        rflush = 1'b0;
        @(posedge rclk); #1;
        check("fetch_flush_dropped", 32'(m_valid), 32'd0);
        check("fetch_flush_rempty", 32'(rempty), 32'd1);
        check("fetch_flush_rptr", 32'(rptr), 32'(3'b001));
        @(negedge rclk);

        // Reset mid-fetch together with flush: reset wins and the read is dropped.
        reset_dut(3'b000);
        rq2_wptr = 3'b011;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            #1;
            got = int'(rd_en);
            @(posedge rclk);
            @(negedge rclk);
        end
        check("rst_fetch_rd_seen", 32'(got), 32'd1);
        rrst = 1'b1; rflush = 1'b1;
        #1;
        check("rst_rd_en_forced", 32'(rd_en), 32'd0);
        @(posedge rclk); #1;
        check("rst_prio_rptr", 32'(rptr), 32'd0);
        check("rst_prio_rempty", 32'(rempty), 32'd1);
        check("rst_prio_m_valid", 32'(m_valid), 32'd0);
        check("rst_prio_m_data", m_data, 32'd0);
        @(negedge rclk);
        rrst = 1'b0; rflush = 1'b0;
        @(posedge rclk); #1;
        check("rst_fetch_dropped", 32'(m_valid), 32'd0);
        @(negedge rclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
